ibuf: RTL and testbench

IBUF -- requirements
Module: ibuf

---
 rtl/common_pkg.sv | 19 +
 rtl/ibuf.sv | 109 ++++++++++
 tb/tb_ibuf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : common
// Purpose : Shared types and constants for the instruction buffer.
//           ibuf_entry_t : one buffered fetch (PC + instruction word)
//           IBUF_DEPTH   : default number of buffer entries
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package common;

   localparam int IBUF_DEPTH = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ibuf_entry_t;

endpackage : common
`default_nettype wire

// File: rtl/ibuf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ibuf
// Purpose : Instruction buffer between the fetch unit and decode. It is a
//           circular FIFO of DEPTH entries with a 1-cycle push-to-visible
//           latency and a flush that discards all contents.
// Ports   : clk                 - clock, rising edge
//           rst                 - asynchronous active-low reset
//           in_valid/in_pc/in_instr/in_ready   - push side (fetch)
//           out_valid/out_pc/out_instr/out_ready - pop side (decode)
//           flush               - redirect: empty the buffer on next edge
//           count               - current occupancy (0..DEPTH)
// Config  : IBUF_BYPASS_EN - when defined, an empty buffer forwards the input
//           combinationally to the output; if decode takes it in that same
//           cycle the entry is not stored.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module ibuf
   import common::*;
#(
   parameter int DEPTH = IBUF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [63:0]              in_pc,
   input  logic [31:0]              in_instr,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [63:0]              out_pc,
   output logic [31:0]              out_instr,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int               PW     = $clog2(DEPTH);
   localparam int               CW     = PW + 1;
   localparam logic [CW-1:0]    C_FULL = CW'(DEPTH);

   ibuf_entry_t   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   ibuf_entry_t   w_head;

   assign w_empty  = (r_count == '0);
   assign in_ready = (r_count != C_FULL);
   assign count    = r_count;

`ifdef IBUF_BYPASS_EN
   logic          w_bypass;

   // Empty buffer: decode sees the incoming fetch directly.
   assign w_bypass  = w_empty && in_valid && out_ready && !flush;
   assign out_valid = (!w_empty || in_valid) && !flush;
   assign w_head    = w_empty ? '{pc: in_pc, instr: in_instr} : r_mem[r_rd_ptr];
   // A bypassed fetch is consumed in flight and never written.
   assign w_push    = in_valid && in_ready && !flush && !w_bypass;
   // Only a stored head frees an entry.
   assign w_pop     = out_valid && out_ready && !w_empty;
`else
   assign out_valid = !w_empty && !flush;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready;
`endif

   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;

   // Pointers and occupancy; flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
      end
   end

endmodule : ibuf
`default_nettype wire

// File: tb/tb_ibuf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_ibuf
// Purpose : Self-checking bench for ibuf. Driver issues directed vectors and
//           pushes expected entries into a scoreboard queue; a monitor pops
//           and compares whenever decode consumes the head.
// Config  : IBUF_BYPASS_EN - enables the bypass expectations and vector.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ibuf;
   import common::*;

   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [63:0]   in_pc;
   logic [31:0]   in_instr;
   logic          in_ready;
   logic          out_valid;
   logic [63:0]   out_pc;
   logic [31:0]   out_instr;
   logic          out_ready;
   logic          flush;
   logic [$clog2(DEPTH):0] count;

   ibuf #(.DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_errors = 0;
   int           m_count  = 0;
   ibuf_entry_t  sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every consumed head must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_unexpected: got pc 0x%0h expected no valid head", out_pc);
         end else begin
            ibuf_entry_t e;
            e = sb.pop_front();
            chk("pop_pc", out_pc, e.pc);
            chk("pop_instr", {32'h0, out_instr}, {32'h0, e.instr});
         end
      end
   end

   // One clock of stimulus; called at posedge+1, returns at next posedge+1.
   task automatic cycle(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
      logic acc, pop, byp, exp_ov;
      in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
      byp = 1'b0;
`ifdef IBUF_BYPASS_EN
      byp    = (m_count == 0) && iv && ordy && !fl;
      exp_ov = ((m_count != 0) || iv) && !fl;
`else
      exp_ov = (m_count != 0) && !fl;
`endif
      acc = iv && (m_count != DEPTH) && !fl && !byp;
      if (fl) sb.delete();
      else if (acc || byp) sb.push_back('{pc: pc, instr: ins});
      @(negedge clk);
      chk("out_valid", {63'h0, out_valid}, {63'h0, exp_ov});
      chk("in_ready", {63'h0, in_ready}, {63'h0, (m_count != DEPTH)});
      chk("count", 64'(count), 64'(m_count));
      pop = exp_ov && ordy && (m_count != 0);
      if (fl) m_count = 0;
      else    m_count = m_count + int'(acc) - int'(pop);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
      out_ready = 1'b0; flush = 1'b0;
      #12;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_out_valid", {63'h0, out_valid}, 64'd0);
      chk("reset_in_ready", {63'h0, in_ready}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single push, visible next cycle.
      cycle(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
      #3;
      chk("first_out_pc", out_pc, 64'h8000_0000);
      #1;
      cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

      // Fill to DEPTH, then try a 5th push while full.
      for (int i = 1; i < 4; i++)
         cycle(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b0, 1'b0);
      cycle(1'b1, 64'h8000_0010, 32'hDEAD_0001, 1'b0, 1'b0);
      // Full rejects even with a simultaneous pop.
      cycle(1'b1, 64'h8000_0099, 32'hDEAD_0002, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

      // Steady push+pop at count=2, wrapping pointers.
      cycle(1'b1, 64'h8000_0100, 32'h0000_1000, 1'b0, 1'b0);
      cycle(1'b1, 64'h8000_0104, 32'h0000_1001, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 64'h8000_0108 + 64'(4 * i), 32'h0000_2000 + 32'(i), 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

      // Flush at count=3 with a same-cycle push.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 64'h8000_0200 + 64'(4 * i), 32'h0000_3000 + 32'(i), 1'b0, 1'b0);
      cycle(1'b1, 64'h8000_0BAD, 32'hBAD0_BAD0, 1'b0, 1'b1);
      cycle(1'b1, 64'h8000_0300, 32'h0000_4000, 1'b0, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream at count=2, with a push in flight.
      cycle(1'b1, 64'h8000_0400, 32'h0000_5000, 1'b0, 1'b0);
      cycle(1'b1, 64'h8000_0404, 32'h0000_5001, 1'b0, 1'b0);
      in_valid = 1'b1; in_pc = 64'h8000_0408; in_instr = 32'h0000_5002;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_out_valid", {63'h0, out_valid}, 64'd0);
      chk("async_rst_in_ready", {63'h0, in_ready}, 64'd1);
      sb.delete();
      m_count = 0;
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0;
      cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

`ifdef IBUF_BYPASS_EN
      // Empty buffer: input passes straight through and is not stored.
      cycle(1'b1, 64'h8000_0010, 32'h0000_0013, 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      // Empty buffer, decode stalled: stored and valid in the same cycle.
      cycle(1'b1, 64'h8000_0020, 32'h0000_0033, 1'b0, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
`endif

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ibuf
`default_nettype wire
